// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter that funnels four valid/ready requesters into
//   one FIFO write port. A requester keeps its grant for up to BURST beats.
//   The grant also ends early if that requester drops valid. The next
//   arbitration then starts one past the requester that was just served.
//   Every grant is preceded by exactly one IDLE cycle. While the FIFO is full
//   the grant is held, but ready and write enable stay low.
//
// Ports
//   i_wclk        write-domain clock, rising edge
//   i_wrst_n      asynchronous active-low reset
//   i_req_valid   [3:0]            per-requester valid
//   i_req_data    [4*DATASIZE-1:0] requester k data at [k*DATASIZE +: DATASIZE]
//   o_req_ready   [3:0]            per-requester ready (combinational)
//   i_wfull_flag                   FIFO full
//   o_fifo_w_en                    FIFO write enable (combinational)
//   o_fifo_wdata  [DATASIZE-1:0]   FIFO write data (combinational)
//   o_grant       [3:0]            one-hot grant, zero in IDLE
//   o_busy                         high while in GRANT
module fifo_wr_arbiter #(
  parameter int DATASIZE = 8,
  parameter int BURST    = 4
) (
  input  logic                  i_wclk,
  input  logic                  i_wrst_n,
  input  logic [3:0]            i_req_valid,
  input  logic [4*DATASIZE-1:0] i_req_data,
  output logic [3:0]            o_req_ready,
  input  logic                  i_wfull_flag,
  output logic                  o_fifo_w_en,
  output logic [DATASIZE-1:0]   o_fifo_wdata,
  output logic [3:0]            o_grant,
  output logic                  o_busy
);

  localparam int CNTW = $clog2(BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state_reg;
  logic [1:0]      rr_ptr_reg;
  logic [1:0]      gidx_reg;
  logic [3:0]      grant_reg;
  logic [CNTW-1:0] beat_cnt_reg;

  logic [3:0]      rot_valid;
  logic [1:0]      sel_off;
  logic [1:0]      sel_idx;
  logic            accept;
  logic [CNTW-1:0] beat_next;

  // Rotate the valid vector so that bit 0 is the requester at rr_ptr.
  // The search below then only has to find the lowest set bit.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_valid[gi] = i_req_valid[rr_ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    sel_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_valid[i]) sel_off = 2'(i);
    end
    sel_idx = rr_ptr_reg + sel_off;
  end

  // Ready is gated by full, so a full FIFO can never produce a write.
  assign o_req_ready  = grant_reg & {4{~i_wfull_flag}};
  assign accept       = |(i_req_valid & o_req_ready);
  assign o_fifo_w_en  = accept;
  assign o_fifo_wdata = (state_reg == GRANT) ? i_req_data[gidx_reg*DATASIZE +: DATASIZE]
                                             : '0;
  assign o_grant      = grant_reg;
  assign o_busy       = (state_reg == GRANT);
  assign beat_next    = beat_cnt_reg + 1'b1;

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= 2'd0;
      gidx_reg     <= 2'd0;
      grant_reg    <= 4'd0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|i_req_valid) begin
            state_reg    <= GRANT;
            gidx_reg     <= sel_idx;
            grant_reg    <= 4'b0001 << sel_idx;
            beat_cnt_reg <= '0;
          end
        end
        default: begin
          // A requester that drops valid gives up its grant at once.
          // Full alone only stalls the grant and never ends it.
          if (!i_req_valid[gidx_reg] ||
              (accept && (beat_next == CNTW'(BURST)))) begin
            state_reg    <= IDLE;
            grant_reg    <= 4'd0;
            rr_ptr_reg   <= gidx_reg + 2'd1;
            beat_cnt_reg <= '0;
          end else if (accept) begin
            beat_cnt_reg <= beat_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter with DATASIZE=8 and BURST=4.
//   Four simple requester models each stream an incrementing word sequence.
//   Inputs are driven on the falling edge. Outputs are sampled 1 ns later,
//   before the next rising edge.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        w_en;
  logic [7:0]  wdata;
  logic [3:0]  grant;
  logic        busy;

  int n_tests;
  int n_fail;

  // Requester models: each requester has an enable, a count of words left,
  // and the next word to send.
  logic [3:0] en;
  int         cnt [4];
  logic [7:0] val [4];
  logic       full_var;
  logic [7:0] fifo_q [$];

  fifo_wr_arbiter #(.DATASIZE(8), .BURST(4)) dut (
    .i_wclk       (clk),
    .i_wrst_n     (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .i_wfull_flag (wfull),
    .o_fifo_w_en  (w_en),
    .o_fifo_wdata (wdata),
    .o_grant      (grant),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      req_valid[k]         = en[k] && (cnt[k] > 0);
      req_data[k*8 +: 8]   = val[k];
    end
    wfull = full_var;
    #1;
  endtask

  // Record the transfers the coming rising edge will perform,
  // then move to the next falling edge.
  task automatic adv();
    for (int k = 0; k < 4; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        val[k] = val[k] + 8'd1;
        cnt[k] = cnt[k] - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 4'd0;
    full_var = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      val[k] = 8'd0;
    end
    rst_n = 1'b0;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, {28'd0, grant}, 32'd0);
    check({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
    check({tag, "_wen"}, {31'd0, w_en}, 32'd0);
    check({tag, "_wdata"}, {24'd0, wdata}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Hand-computed response for requester 2 sending 1..6.
  logic [8:0]  t1_we;
  logic [3:0]  t1_g [9];
  logic [7:0]  t1_d [9];

  int         seen [64];
  int         reads;
  int         writes;
  int         cyc;
  int         src;
  logic [7:0] exp_next [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    @(negedge clk);

    // Reset state, with a requester already valid.
    do_reset();
    rst_n = 1'b0;
    en = 4'b0001; cnt[0] = 3; val[0] = 8'h55;
    drive();
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester: bursts of 4 and then 2, with one IDLE cycle between them.
    t1_we = 9'b0_1101_1110;   // bit c is cycle c
    t1_g  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4};
    t1_d  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd5, 8'd6, 8'd0};
    do_reset();
    en = 4'b0100; cnt[2] = 6; val[2] = 8'd1;
    for (int c = 0; c < 9; c++) begin
      drive();
      check($sformatf("t1_wen_c%0d", c), {31'd0, w_en}, {31'd0, t1_we[c]});
      check($sformatf("t1_grant_c%0d", c), {28'd0, grant}, {28'd0, t1_g[c]});
      if (t1_we[c] || c == 0)
        check($sformatf("t1_wdata_c%0d", c), {24'd0, wdata}, {24'd0, t1_d[c]});
      adv();
    end
    drive();
    check("t1_end_busy", {31'd0, busy}, 32'd0);

    // All four valid: grants go 0,1,2,3,0, with 4 writes each.
    do_reset();
    en = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 20;
      val[k] = 8'(k * 16);
    end
    for (int g = 0; g < 5; g++) begin
      drive();
      check($sformatf("t2_bubble_g%0d", g), {27'd0, grant, w_en}, 32'd0);
      adv();
      for (int b = 0; b < 4; b++) begin
        drive();
        check($sformatf("t2_grant_g%0d_b%0d", g, b), {28'd0, grant}, 32'd1 << (g % 4));
        check($sformatf("t2_wen_g%0d_b%0d", g, b), {31'd0, w_en}, 32'd1);
        check($sformatf("t2_wdata_g%0d_b%0d", g, b), {24'd0, wdata},
              32'((g % 4) * 16 + (g / 4) * 4 + b));
        adv();
      end
    end

    // Full stall after beat 2 for 5 cycles.
    do_reset();
    en = 4'b0001; cnt[0] = 10; val[0] = 8'd1;
    drive(); adv();                       // IDLE
    for (int b = 1; b <= 2; b++) begin
      drive();
      check($sformatf("t3_wdata_b%0d", b), {23'd0, w_en, wdata}, {23'd0, 1'b1, 8'(b)});
      adv();
    end
    full_var = 1'b1;
    for (int s = 0; s < 5; s++) begin
      drive();
      check($sformatf("t3_stall_wen_s%0d", s), {31'd0, w_en}, 32'd0);
      check($sformatf("t3_stall_ready_s%0d", s), {28'd0, req_ready}, 32'd0);
      check($sformatf("t3_stall_grant_s%0d", s), {27'd0, grant, busy}, {27'd0, 4'b0001, 1'b1});
      adv();
    end
    full_var = 1'b0;
    for (int b = 3; b <= 4; b++) begin
      drive();
      check($sformatf("t3_wdata_b%0d", b), {23'd0, w_en, wdata}, {23'd0, 1'b1, 8'(b)});
      adv();
    end
    drive();
    check("t3_after_burst_grant", {28'd0, grant}, 32'd0);

    // Early drop by requester 1: requester 3 must come next, ahead of requester 0.
    do_reset();
    en = 4'b1010; cnt[1] = 2; val[1] = 8'h10; cnt[3] = 10; val[3] = 8'h30;
    cnt[0] = 10; val[0] = 8'h00;
    drive();
    check("t4_idle_grant", {28'd0, grant}, 32'd0);
    adv();
    en = 4'b1011;                         // requester 0 becomes valid now
    for (int b = 0; b < 2; b++) begin
      drive();
      check($sformatf("t4_r1_b%0d", b), {19'd0, grant, w_en, wdata},
            {19'd0, 4'b0010, 1'b1, 8'(8'h10 + b)});
      adv();
    end
    drive();
    check("t4_drop_cycle", {27'd0, grant, w_en}, {27'd0, 4'b0010, 1'b0});
    adv();
    drive();
    check("t4_idle_again", {27'd0, grant, busy}, 32'd0);
    adv();
    drive();
    check("t4_next_is_r3", {19'd0, grant, w_en, wdata}, {19'd0, 4'b1000, 1'b1, 8'h30});
    adv();

    // Reset pulsed during a burst from requester 3.
    do_reset();
    en = 4'b1000; cnt[3] = 10; val[3] = 8'h30;
    drive(); adv();
    drive();
    check("t5_beat1", {19'd0, grant, w_en, wdata}, {19'd0, 4'b1000, 1'b1, 8'h30});
    adv();
    rst_n = 1'b0;
    en = 4'b1001; cnt[0] = 10; val[0] = 8'h00;
    drive();
    check_zero("t5_rst_a");
    adv();
    drive();
    check_zero("t5_rst_b");
    adv();
    rst_n = 1'b1;
    drive();
    check("t5_post_idle", {27'd0, grant, w_en}, 32'd0);
    adv();
    drive();
    check("t5_first_r0", {19'd0, grant, w_en, wdata}, {19'd0, 4'b0001, 1'b1, 8'h00});
    adv();

    // Integration against a depth-16 FIFO with a random-rate reader.
    do_reset();
    en = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 16;
      val[k] = 8'(k * 16);
      exp_next[k] = 8'(k * 16);
    end
    for (int i = 0; i < 64; i++) seen[i] = 0;
    fifo_q.delete();
    reads = 0; writes = 0; cyc = 0;
    while (reads < 64 && cyc < 3000) begin
      full_var = (fifo_q.size() == 16);
      drive();
      if (full_var) check("t6_write_when_full", {31'd0, w_en}, 32'd0);
      if (w_en) begin
        src = 0;
        for (int k = 0; k < 4; k++) if (grant[k]) src = k;
        check($sformatf("t6_order_r%0d", src), {24'd0, wdata}, {24'd0, exp_next[src]});
        exp_next[src] = exp_next[src] + 8'd1;
      end
      if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        if (fifo_q[0] < 64) seen[fifo_q[0]]++;
        void'(fifo_q.pop_front());
        reads++;
      end
      if (w_en && !full_var) begin
        fifo_q.push_back(wdata);
        writes++;
      end
      adv();
      cyc++;
    end
    check("t6_timeout", {31'd0, (cyc >= 3000)}, 32'd0);
    check("t6_writes", 32'(writes), 32'd64);
    for (int i = 0; i < 64; i++)
      if (seen[i] != 1) check($sformatf("t6_once_w%0d", i), 32'(seen[i]), 32'd1);
    check("t6_fifo_empty", 32'(fifo_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
